// File: rtl/x_uart_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : x_uart_tx_fifo                                               |
// | Description : UART transmitter fed by a small word FIFO. Words are pushed  |
// |               with a valid/accept handshake and serialised as            |
// |               start / data (LSB first) / optional parity / stop bits.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module x_uart_tx_fifo #(
  parameter int p_clk_hz    = 50000000,
  parameter int p_baud      = 115200,
  parameter int p_data_bits = 8,
  parameter int p_parity    = 0,
  parameter int p_stop_bits = 1,
  parameter int p_depth     = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [p_data_bits-1:0]   i_data,
  input  logic                     i_valid,
  output logic                     o_accept,
  output logic                     o_tx,
  output logic                     o_busy,
  output logic [$clog2(p_depth):0] o_level
);

  localparam int c_div = p_clk_hz / p_baud;
  localparam int c_cw  = (c_div > 1) ? $clog2(c_div) : 1;
  localparam int c_aw  = $clog2(p_depth);

  localparam logic [c_cw-1:0] c_baud_last = c_cw'(c_div - 1);
  localparam logic [c_aw:0]   c_full      = (c_aw + 1)'(p_depth);
  localparam logic [2:0]      c_data_last = 3'(p_data_bits - 1);
  localparam logic [2:0]      c_stop_last = 3'(p_stop_bits - 1);
  localparam logic            c_par_odd   = (p_parity == 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                 r_state;
  logic                   r_tx;
  logic [c_cw-1:0]        r_baud;
  logic [2:0]             r_bit;
  logic [p_data_bits-1:0] r_shift;
  logic                   r_par;
  logic [c_aw-1:0]        r_wptr;
  logic [c_aw-1:0]        r_rptr;
  logic [c_aw:0]          r_level;
  logic [p_data_bits-1:0] r_mem [p_depth];

  state_t                 w_state_nx;
  logic                   w_tx_nx;
  logic [c_cw-1:0]        w_baud_nx;
  logic [2:0]             w_bit_nx;
  logic [p_data_bits-1:0] w_shift_nx;
  logic                   w_par_nx;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_tick;
  logic [p_data_bits-1:0] w_head;

  assign o_accept = (r_level < c_full);
  assign w_push   = i_valid & o_accept;
  assign w_head   = r_mem[r_rptr];
  assign w_tick   = (r_baud == c_baud_last);

  assign o_tx     = r_tx;
  assign o_level  = r_level;
  assign o_busy   = (r_state != S_IDLE) | (r_level != '0);

  // Storage array; stale entries are harmless since pointers define validity.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  // FIFO pointers and occupancy; push and pop together leave the level unchanged.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_aw'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_aw'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (c_aw + 1)'(1);
        2'b01:   r_level <= r_level - (c_aw + 1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Transmitter state register; o_tx comes straight from r_tx so it never glitches.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_tx    <= 1'b1;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_tx    <= w_tx_nx;
      r_baud  <= w_baud_nx;
      r_bit   <= w_bit_nx;
      r_shift <= w_shift_nx;
      r_par   <= w_par_nx;
    end
  end

  // Next-state and next-line-level logic; a pop always launches a new start bit.
  always_comb begin
    w_state_nx = r_state;
    w_tx_nx    = r_tx;
    w_baud_nx  = r_baud;
    w_bit_nx   = r_bit;
    w_shift_nx = r_shift;
    w_par_nx   = r_par;
    w_pop      = 1'b0;

    if (r_state != S_IDLE) begin
      w_baud_nx = w_tick ? '0 : r_baud + c_cw'(1);
    end

    case (r_state)
      S_IDLE: begin
        w_tx_nx = 1'b1;
        if (r_level != '0) begin
          w_pop = 1'b1;
        end
      end
      S_START: begin
        if (w_tick) begin
          w_state_nx = S_DATA;
          w_tx_nx    = r_shift[0];
          w_bit_nx   = '0;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          if (r_bit == c_data_last) begin
            w_bit_nx = '0;
            if (p_parity != 0) begin
              w_state_nx = S_PARITY;
              w_tx_nx    = r_par;
            end else begin
              w_state_nx = S_STOP;
              w_tx_nx    = 1'b1;
            end
          end else begin
            w_bit_nx   = r_bit + 3'd1;
            w_shift_nx = r_shift >> 1;
            w_tx_nx    = r_shift[1];
          end
        end
      end
      S_PARITY: begin
        if (w_tick) begin
          w_state_nx = S_STOP;
          w_tx_nx    = 1'b1;
          w_bit_nx   = '0;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          if (r_bit == c_stop_last) begin
            if (r_level != '0) begin
              w_pop = 1'b1;
            end else begin
              w_state_nx = S_IDLE;
              w_tx_nx    = 1'b1;
            end
          end else begin
            w_bit_nx = r_bit + 3'd1;
          end
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_tx_nx    = 1'b1;
      end
    endcase

    // Loading the head word: parity is precomputed so it is ready after the data bits.
    if (w_pop) begin
      w_state_nx = S_START;
      w_tx_nx    = 1'b0;
      w_baud_nx  = '0;
      w_bit_nx   = '0;
      w_shift_nx = w_head;
      w_par_nx   = (^w_head) ^ c_par_odd;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_x_uart_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_x_uart_tx_fifo                                            |
// | Description : Directed bench for x_uart_tx_fifo; an 8N1 instance and a     |
// |               7O2 instance are driven, and a line monitor decodes frames  |
// |               against a queue of expected frames.                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_x_uart_tx_fifo;

  localparam int DIV   = 10;
  localparam int LEN_A = 10;
  localparam int LEN_B = 11;

  logic       clk = 1'b0;
  logic       rst_a_n, rst_b_n;
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic       valid_a, valid_b;
  logic       accept_a, accept_b;
  logic       tx_a, tx_b;
  logic       busy_a, busy_b;
  logic [2:0] level_a;
  logic [1:0] level_b;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  logic [15:0] exp_a[$];
  logic [15:0] exp_b[$];
  int          starts_a[$];

  int          full_lvl [8] = '{1, 1, 2, 3, 4, 4, 4, 4};
  logic        full_acc [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
  logic [6:0]  b_words  [4] = '{7'h7F, 7'h2A, 7'h55, 7'h11};
  int          b_lvl    [4] = '{1, 1, 2, 2};
  logic        b_acc    [4] = '{1, 1, 0, 0};

  x_uart_tx_fifo #(
    .p_clk_hz(1000000), .p_baud(100000), .p_data_bits(8),
    .p_parity(0), .p_stop_bits(1), .p_depth(4)
  ) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_a_n), .i_data(data_a), .i_valid(valid_a),
    .o_accept(accept_a), .o_tx(tx_a), .o_busy(busy_a), .o_level(level_a)
  );

  x_uart_tx_fifo #(
    .p_clk_hz(1000000), .p_baud(100000), .p_data_bits(7),
    .p_parity(2), .p_stop_bits(2), .p_depth(2)
  ) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_b_n), .i_data(data_b), .i_valid(valid_b),
    .o_accept(accept_b), .o_tx(tx_b), .o_busy(busy_b), .o_level(level_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected line bits, index 0 = start bit.
  function automatic logic [15:0] frame_a(input logic [7:0] d);
    return {6'b0, 1'b1, d, 1'b0};
  endfunction

  function automatic logic [15:0] frame_b(input logic [6:0] d);
    logic p;
    p = (($countones(d) % 2) == 0);
    return {5'b0, 2'b11, p, d, 1'b0};
  endfunction

  // Line monitor: samples every cycle of a frame, requires each bit to be stable
  // for its whole DIV window, then compares against the scoreboard head.
  logic [15:0] m_bits [2];
  int          m_cyc  [2];
  bit          m_act  [2];
  bit          m_stab [2];
  int          done_cnt [2];
  logic        mon_tx, mon_rn;
  int          mon_len, mon_bi;
  logic [15:0] mon_mask, mon_exp;
  bit          mon_have;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      mon_tx  = (d == 0) ? tx_a : tx_b;
      mon_rn  = (d == 0) ? rst_a_n : rst_b_n;
      mon_len = (d == 0) ? LEN_A : LEN_B;
      if (mon_rn !== 1'b1) begin
        m_act[d] = 1'b0;
      end else begin
        if (!m_act[d] && mon_tx === 1'b0) begin
          m_act[d]  = 1'b1;
          m_cyc[d]  = 0;
          m_bits[d] = '1;
          m_stab[d] = 1'b1;
          if (d == 0) starts_a.push_back(cycle);
        end
        if (m_act[d]) begin
          mon_bi = m_cyc[d] / DIV;
          if ((m_cyc[d] % DIV) == 0) m_bits[d][mon_bi] = mon_tx;
          else if (mon_tx !== m_bits[d][mon_bi]) m_stab[d] = 1'b0;
          m_cyc[d]++;
          if (m_cyc[d] == mon_len * DIV) begin
            m_act[d] = 1'b0;
            done_cnt[d]++;
            mon_mask = (16'h1 << mon_len) - 16'h1;
            mon_have = (d == 0) ? (exp_a.size() != 0) : (exp_b.size() != 0);
            check($sformatf("frame_expected_dut%0d", d), mon_have, 1);
            if (mon_have) begin
              if (d == 0) mon_exp = exp_a.pop_front();
              else        mon_exp = exp_b.pop_front();
              check($sformatf("frame_bits_dut%0d", d), m_bits[d] & mon_mask, mon_exp);
              check($sformatf("frame_timing_dut%0d", d), m_stab[d], 1);
            end
          end
        end
      end
    end
  end

  task automatic wait_done(input int d, input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt[d] < target && n < budget) begin
      step();
      n++;
    end
    check($sformatf("frame_wait_dut%0d", d), done_cnt[d] >= target, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    valid_a = 1'b0; valid_b = 1'b0;
    data_a  = '0;   data_b  = '0;
    repeat (3) step();
    check("rst_tx_a", tx_a, 1);
    check("rst_level_a", level_a, 0);
    check("rst_busy_a", busy_a, 0);
    check("rst_accept_a", accept_a, 1);
    check("rst_tx_b", tx_b, 1);
    check("rst_level_b", level_b, 0);
    rst_a_n = 1'b1; rst_b_n = 1'b1;
    step();

    // 8N1 single frame 0xA5
    exp_a.push_back(frame_a(8'hA5));
    valid_a = 1'b1; data_a = 8'hA5;
    step();
    valid_a = 1'b0;
    check("a5_level_push", level_a, 1);
    check("a5_tx_idle", tx_a, 1);
    check("a5_busy_push", busy_a, 1);
    step();
    check("a5_tx_start", tx_a, 0);
    check("a5_level_pop", level_a, 0);
    repeat (99) step();
    check("a5_busy_stop", busy_a, 1);
    check("a5_tx_stop", tx_a, 1);
    step();
    check("a5_busy_end", busy_a, 0);
    check("a5_tx_end", tx_a, 1);
    check("a5_done", done_cnt[0], 1);

    // Back-to-back frames with no idle gap
    starts_a.delete();
    exp_a.push_back(frame_a(8'h00));
    exp_a.push_back(frame_a(8'hFF));
    exp_a.push_back(frame_a(8'h55));
    valid_a = 1'b1; data_a = 8'h00;
    step();
    check("b2b_level1", level_a, 1);
    data_a = 8'hFF;
    step();
    check("b2b_level2", level_a, 1);
    data_a = 8'h55;
    step();
    valid_a = 1'b0;
    check("b2b_level3", level_a, 2);
    wait_done(0, 2, 200);
    check("b2b_level_f1", level_a, 1);
    wait_done(0, 3, 200);
    check("b2b_level_f2", level_a, 0);
    wait_done(0, 4, 200);
    check("b2b_starts", starts_a.size(), 3);
    if (starts_a.size() == 3) begin
      check("b2b_gap1", starts_a[1] - starts_a[0], 100);
      check("b2b_gap2", starts_a[2] - starts_a[1], 100);
    end

    // FIFO full: only accepted words are sent
    for (int i = 0; i < 5; i++) exp_a.push_back(frame_a(8'h10 + 8'(i)));
    for (int i = 0; i < 8; i++) begin
      data_a = 8'h10 + 8'(i); valid_a = 1'b1;
      step();
      check($sformatf("full_level_%0d", i), level_a, full_lvl[i]);
      check($sformatf("full_accept_%0d", i), accept_a, full_acc[i]);
    end
    valid_a = 1'b0;
    wait_done(0, 9, 600);
    check("full_level_end", level_a, 0);
    check("full_busy_end", busy_a, 0);

    // Push on the edge where STOP ends while one word is waiting
    exp_a.push_back(frame_a(8'h81));
    exp_a.push_back(frame_a(8'h42));
    exp_a.push_back(frame_a(8'hC3));
    valid_a = 1'b1; data_a = 8'h81;
    step();
    data_a = 8'h42;
    step();
    valid_a = 1'b0;
    check("pp_level_pre", level_a, 1);
    repeat (99) step();
    valid_a = 1'b1; data_a = 8'hC3;
    step();
    valid_a = 1'b0;
    check("pp_level", level_a, 1);
    check("pp_tx_start", tx_a, 0);
    check("pp_done1", done_cnt[0], 10);
    wait_done(0, 12, 400);
    check("pp_level_end", level_a, 0);

    // Reset in the middle of data bit 3
    valid_a = 1'b1; data_a = 8'h00;
    step();
    data_a = 8'h77;
    step();
    valid_a = 1'b0;
    repeat (44) step();
    check("mr_tx_bit3", tx_a, 0);
    check("mr_level_pre", level_a, 1);
    #2 rst_a_n = 1'b0;
    #1;
    check("mr_tx_rst", tx_a, 1);
    check("mr_level_rst", level_a, 0);
    check("mr_busy_rst", busy_a, 0);
    check("mr_accept_rst", accept_a, 1);
    step();
    exp_a.push_back(frame_a(8'h3C));
    rst_a_n = 1'b1; valid_a = 1'b1; data_a = 8'h3C;
    step();
    valid_a = 1'b0;
    check("mr_level_first", level_a, 1);
    step();
    check("mr_tx_start", tx_a, 0);
    wait_done(0, 13, 200);
    check("mr_busy_end", busy_a, 0);

    // 7O2 frame 0x03
    exp_b.push_back(frame_b(7'h03));
    valid_b = 1'b1; data_b = 7'h03;
    step();
    valid_b = 1'b0;
    check("b03_level", level_b, 1);
    step();
    check("b03_tx_start", tx_b, 0);
    repeat (109) step();
    check("b03_busy_stop", busy_b, 1);
    check("b03_tx_stop", tx_b, 1);
    step();
    check("b03_busy_end", busy_b, 0);
    check("b03_done", done_cnt[1], 1);

    // Depth-2 FIFO on the 7O2 instance: pointer wrap and full
    for (int i = 0; i < 3; i++) exp_b.push_back(frame_b(b_words[i]));
    for (int i = 0; i < 4; i++) begin
      data_b = b_words[i]; valid_b = 1'b1;
      step();
      check($sformatf("bfull_level_%0d", i), level_b, b_lvl[i]);
      check($sformatf("bfull_accept_%0d", i), accept_b, b_acc[i]);
    end
    valid_b = 1'b0;
    wait_done(1, 4, 500);
    check("bfull_level_end", level_b, 0);
    check("bfull_busy_end", busy_b, 0);

    step();
    check("sb_empty_a", exp_a.size(), 0);
    check("sb_empty_b", exp_b.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
